// File: rtl/vram_arbiter_if.sv
// Bus bundle for the pixel RAM arbiter: PPU read port, CPU read/write port,
// external RAM pins and the PPU miss counter. The slave modport is the
// arbiter's view; the master modport is the surrounding system's view.
interface vram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  // PPU (display fetch) read-only port
  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_gnt;
  logic              ppu_rvalid;
  logic [DATA_W-1:0] ppu_rdata;

  // CPU read/write port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  // External RAM pins
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic [15:0]       ppu_miss_cnt;

  modport slave (
    input  ppu_req, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output ppu_gnt, ppu_rvalid, ppu_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, ppu_miss_cnt
  );

  modport master (
    output ppu_req, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  ppu_gnt, ppu_rvalid, ppu_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, ppu_miss_cnt
  );
endinterface

// File: rtl/vram_arbiter.sv
// Pixel RAM arbiter: PPU has fixed priority over the CPU, except that a CPU
// denied STARVE_LIMIT consecutive cycles is forced through. One grant per
// cycle; commands are registered toward the RAM and read data returns two
// cycles after the grant, steered by a one-bit owner tag.
module vram_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  logic [7:0]        starve_cnt_reg;
  logic [15:0]       ppu_miss_cnt_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;
  logic              tag_cpu_reg;     // owner of the read currently on the RAM pins
  logic              ppu_rvalid_reg;
  logic              cpu_rvalid_reg;

  logic              force_cpu;
  logic              ppu_gnt_next;
  logic              cpu_gnt_next;

  // Arbitration: a starved CPU overrides the PPU, otherwise PPU first.
  always_comb begin
    force_cpu    = bus.cpu_req && (starve_cnt_reg == 8'(STARVE_LIMIT));
    ppu_gnt_next = bus.ppu_req && !force_cpu;
    cpu_gnt_next = bus.cpu_req && (force_cpu || !bus.ppu_req);
  end

  // Starvation and PPU miss bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg   <= '0;
      ppu_miss_cnt_reg <= '0;
    end else begin
      if (cpu_gnt_next || !bus.cpu_req)
        starve_cnt_reg <= '0;
      else if (starve_cnt_reg != 8'(STARVE_LIMIT))
        starve_cnt_reg <= starve_cnt_reg + 8'd1;
      if (bus.ppu_req && !ppu_gnt_next && (ppu_miss_cnt_reg != 16'hFFFF))
        ppu_miss_cnt_reg <= ppu_miss_cnt_reg + 16'd1;
    end
  end

  // Command stage: register the granted request onto the RAM pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      tag_cpu_reg   <= 1'b0;
    end else begin
      mem_read_reg  <= ppu_gnt_next || (cpu_gnt_next && !bus.cpu_we);
      mem_write_reg <= cpu_gnt_next && bus.cpu_we;
      tag_cpu_reg   <= cpu_gnt_next;
      if (ppu_gnt_next) begin
        mem_addr_reg <= bus.ppu_addr;
      end else if (cpu_gnt_next) begin
        mem_addr_reg <= bus.cpu_addr;
        if (bus.cpu_we)
          mem_wdata_reg <= bus.cpu_wdata;
      end
    end
  end

  // Response stage: one rvalid pulse to the owner of each issued read.
  always_ff @(posedge clk) begin
    if (reset) begin
      ppu_rvalid_reg <= 1'b0;
      cpu_rvalid_reg <= 1'b0;
    end else begin
      ppu_rvalid_reg <= mem_read_reg && !tag_cpu_reg;
      cpu_rvalid_reg <= mem_read_reg && tag_cpu_reg;
    end
  end

  assign bus.ppu_gnt      = ppu_gnt_next;
  assign bus.cpu_gnt      = cpu_gnt_next;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.mem_wdata    = mem_wdata_reg;
  assign bus.mem_read     = mem_read_reg;
  assign bus.mem_write    = mem_write_reg;
  assign bus.ppu_rvalid   = ppu_rvalid_reg;
  assign bus.cpu_rvalid   = cpu_rvalid_reg;
  assign bus.ppu_rdata    = bus.mem_rdata;
  assign bus.cpu_rdata    = bus.mem_rdata;
  assign bus.ppu_miss_cnt = ppu_miss_cnt_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a transaction-level model (pending-read list with
// due cycles, denied-streak and miss counters) is checked against the DUT on
// every cycle, and the stimulus pins hand-computed literal values per cycle.
module tb_vram_arbiter;
  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: data is a fixed pattern of the address, one cycle after mem_read
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {12'hA5A, a};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_rdata <= pat(bus.mem_addr);
  end

  // Literal expectations set by the stimulus for the current cycle
  localparam int ID_PGNT = 1, ID_CGNT = 2, ID_MRD = 3, ID_MWR = 4, ID_MADDR = 5,
                 ID_MWDATA = 6, ID_PRV = 7, ID_CRV = 8, ID_PRDATA = 9,
                 ID_MISS = 10, ID_CRDATA = 11;
  int          pin_id [4];
  logic [63:0] pin_val [4];
  bit          sync_miss = 1'b0;

  function automatic logic [63:0] sel(input int id);
    case (id)
      ID_PGNT:   return 64'(bus.ppu_gnt);
      ID_CGNT:   return 64'(bus.cpu_gnt);
      ID_MRD:    return 64'(bus.mem_read);
      ID_MWR:    return 64'(bus.mem_write);
      ID_MADDR:  return 64'(bus.mem_addr);
      ID_MWDATA: return 64'(bus.mem_wdata);
      ID_PRV:    return 64'(bus.ppu_rvalid);
      ID_CRV:    return 64'(bus.cpu_rvalid);
      ID_PRDATA: return 64'(bus.ppu_rdata);
      ID_MISS:   return 64'(bus.ppu_miss_cnt);
      ID_CRDATA: return 64'(bus.cpu_rdata);
      default:   return 64'hDEAD_0000_0000_0000;
    endcase
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  typedef struct {
    int             due;
    bit             is_cpu;
    logic [AW-1:0]  addr;
  } resp_t;
  resp_t         resp_q[$];
  int            cyc = 0;
  bit            m_valid = 1'b0;
  int            m_streak;     // consecutive cycles the CPU asked and was refused
  int            m_miss;
  bit            m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            e_force, e_pg, e_cg, due_now;
  resp_t         r;

  // Single compare process: check this cycle, then advance the model over the edge
  always @(negedge clk) begin
    cyc++;
    e_force = bus.cpu_req && (m_streak == LIM);
    e_pg    = bus.ppu_req && !e_force;
    e_cg    = bus.cpu_req && !e_pg;
    due_now = (resp_q.size() > 0) && (resp_q[0].due == cyc);

    if (m_valid) begin
      check("ppu_gnt", 64'(bus.ppu_gnt), 64'(e_pg));
      check("cpu_gnt", 64'(bus.cpu_gnt), 64'(e_cg));
      check("mem_read", 64'(bus.mem_read), 64'(m_rd));
      check("mem_write", 64'(bus.mem_write), 64'(m_wr));
      check("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
      check("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
      check("ppu_rvalid", 64'(bus.ppu_rvalid), 64'(due_now && !resp_q[0].is_cpu));
      check("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(due_now && resp_q[0].is_cpu));
      if (!sync_miss) check("ppu_miss_cnt", 64'(bus.ppu_miss_cnt), 64'(m_miss));
      if (due_now) begin
        check("rdata", 64'(resp_q[0].is_cpu ? bus.cpu_rdata : bus.ppu_rdata),
              64'(pat(resp_q[0].addr)));
        $display("cycle %0d: %s rvalid addr=%05h data=%08h", cyc,
                 resp_q[0].is_cpu ? "cpu" : "ppu", resp_q[0].addr, bus.mem_rdata);
        void'(resp_q.pop_front());
      end
    end

    for (int k = 0; k < 4; k++)
      if (pin_id[k] != 0) check($sformatf("pin%0d", pin_id[k]), sel(pin_id[k]), pin_val[k]);

    if (reset) begin
      m_valid  = 1'b1;
      m_streak = 0;
      m_miss   = 0;
      m_rd     = 1'b0;
      m_wr     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      resp_q.delete();
    end else if (m_valid) begin
      m_rd = e_pg || (e_cg && !bus.cpu_we);
      m_wr = e_cg && bus.cpu_we;
      if (e_pg) m_addr = bus.ppu_addr;
      else if (e_cg) m_addr = bus.cpu_addr;
      if (e_cg && bus.cpu_we) m_wdata = bus.cpu_wdata;
      if (m_rd) begin
        r.due = cyc + 2; r.is_cpu = e_cg; r.addr = m_addr;
        resp_q.push_back(r);
      end
      if (e_pg || e_cg)
        $display("cycle %0d: grant %s %s addr=%05h", cyc, e_pg ? "ppu" : "cpu",
                 m_wr ? "write" : "read", m_addr);
      if (e_cg || !bus.cpu_req) m_streak = 0;
      else if (m_streak < LIM) m_streak++;
      if (bus.ppu_req && !e_pg && m_miss < 16'hFFFF) m_miss++;
      if (sync_miss) m_miss = 16'hFFFE;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) pin_id[k] = 0;
  endtask

  task automatic pin(input int slot, input int id, input logic [63:0] val);
    pin_id[slot]  = id;
    pin_val[slot] = val;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin pin_id[k] = 0; pin_val[k] = '0; end
    bus.ppu_req = 0; bus.ppu_addr = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    // reset state
    pin(0, ID_MRD, 0); pin(1, ID_MADDR, 0); pin(2, ID_MWDATA, 0); pin(3, ID_MISS, 0);
    tick();

    // PPU-only burst at 0,4,8
    bus.ppu_req = 1; bus.ppu_addr = 20'h0; pin(0, ID_PGNT, 1);
    tick();
    bus.ppu_addr = 20'h4; pin(0, ID_MADDR, 0); pin(1, ID_MRD, 1);
    tick();
    bus.ppu_addr = 20'h8; pin(0, ID_MADDR, 4); pin(1, ID_PRV, 1); pin(2, ID_PRDATA, 32'hA5A00000);
    tick();
    bus.ppu_req = 0; pin(0, ID_MADDR, 8); pin(1, ID_MRD, 1); pin(2, ID_PRV, 1);
    pin(3, ID_PRDATA, 32'hA5A00004);
    tick();
    pin(0, ID_PRV, 1); pin(1, ID_PRDATA, 32'hA5A00008); pin(2, ID_MRD, 0);
    tick();
    pin(0, ID_PRV, 0);
    tick();

    // CPU write
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 20'h00010; bus.cpu_wdata = 32'hDEADBEEF;
    pin(0, ID_CGNT, 1); pin(1, ID_PGNT, 0);
    tick();
    bus.cpu_req = 0; bus.cpu_we = 0;
    pin(0, ID_MWR, 1); pin(1, ID_MADDR, 20'h00010); pin(2, ID_MWDATA, 32'hDEADBEEF); pin(3, ID_MRD, 0);
    tick();
    pin(0, ID_CRV, 0); pin(1, ID_MWR, 0); pin(2, ID_MWDATA, 32'hDEADBEEF);
    tick();
    pin(0, ID_CRV, 0);
    tick();

    // Both requesting: 8 PPU grants then a forced CPU grant, twice
    bus.ppu_req = 1; bus.ppu_addr = 20'h00200;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 20'h00100;
    for (int i = 0; i < 18; i++) begin
      pin(0, ID_CGNT, 64'((i % 9) == 8)); pin(1, ID_PGNT, 64'((i % 9) != 8));
      tick();
    end
    bus.ppu_req = 0; bus.cpu_req = 0;
    pin(0, ID_MISS, 2);
    tick();
    repeat (3) tick();

    // PPU read then CPU read on consecutive cycles
    bus.ppu_req = 1; bus.ppu_addr = 20'h00300; pin(0, ID_PGNT, 1);
    tick();
    bus.ppu_req = 0; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 20'h00304; pin(0, ID_CGNT, 1);
    tick();
    bus.cpu_req = 0; pin(0, ID_PRV, 1); pin(1, ID_CRV, 0); pin(2, ID_PRDATA, 32'hA5A00300);
    tick();
    pin(0, ID_CRV, 1); pin(1, ID_PRV, 0); pin(2, ID_CRDATA, 32'hA5A00304);
    tick();
    pin(0, ID_CRV, 0); pin(1, ID_PRV, 0);
    tick();

    // Reset during the command cycle of a CPU read
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 20'h00400; pin(0, ID_CGNT, 1);
    tick();
    bus.cpu_req = 0; reset = 1'b1; pin(0, ID_MRD, 1); pin(1, ID_MADDR, 20'h00400);
    tick();
    reset = 1'b0;
    pin(0, ID_CRV, 0); pin(1, ID_MRD, 0); pin(2, ID_MADDR, 0); pin(3, ID_MISS, 0);
    tick();
    pin(0, ID_CRV, 0); pin(1, ID_MWDATA, 0); pin(2, ID_PRV, 0);
    tick();

    // Miss counter saturation from 16'hFFFE
    force dut.ppu_miss_cnt_reg = 16'hFFFE;
    sync_miss = 1'b1;
    pin(0, ID_MISS, 16'hFFFE);
    @(negedge clk);
    #1;
    release dut.ppu_miss_cnt_reg;
    sync_miss = 1'b0;
    tick();
    pin(0, ID_MISS, 16'hFFFE);
    bus.ppu_req = 1; bus.ppu_addr = 20'h00500;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 20'h00600;
    tick();
    for (int i = 1; i < 27; i++) tick();
    bus.ppu_req = 0; bus.cpu_req = 0;
    pin(0, ID_MISS, 16'hFFFF);
    tick();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
